pixel_stream_packer: RTL and testbench
======================================

PIXEL_STREAM_PACKER -- requirements
Module: pixel_stream_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >= 2): number of output buffer entries.
REQ-002 SHALL have port aclk, input, 1: single clock; all logic on the rising edge.
REQ-003 SHALL have port aresetn, input, 1: synchronous, active-low reset.
REQ-004 SHALL have ports image_width and image_height, input, 13 each: frame geometry in pixels; value 0 is treated as 1.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_r / in_g / in_b (input, 8 each), in_sof (input, 1), in_eol (input, 1): pixel stream from the ray-tracing unit.
REQ-006 SHALL have ports m_axis_tdata (output, 24; {r,g,b} with r in [23:16]), m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tuser (output, 1; SOF), m_axis_tlast (output, 1; EOL): AXI4-Stream video out.
REQ-007 SHALL have port clear_err, input, 1: clears the sticky error flags.
REQ-008 SHALL have ports sof_err and eol_err, output, 1 each: sticky framing-error flags.
REQ-009 SHALL have port frame_count, output, 16: count of completed frames.

Function
REQ-010 SHALL accept a pixel on a cycle with in_valid=1 and in_ready=1.
REQ-011 SHALL drive in_ready = (fifo_count < FIFO_DEPTH) from registered state only; there is no combinational path from m_axis_tready.
REQ-012 SHALL keep write-side position counters x and y (13 bits each); on each accept, SHALL compute sof_c = (x==0 && y==0) and eol_c = (x==W-1).
REQ-013 SHALL latch W/H from image_width/image_height on an accept at position (0,0) and use the latched values for the rest of that frame; the accept at (0,0) itself SHALL use the live inputs.
REQ-014 SHALL advance the counters after each accept:
- x increments;
- at x==W-1, x wraps to 0 and y increments;
- at x==W-1 and y==H-1, both wrap to 0 and frame_count increments (wraps modulo 2^16).
REQ-015 SHALL handle in_sof=1 accepted at a position other than (0,0) as follows:
- set sof_err;
- store the pixel with tuser=1;
- resync the counters as if the pixel were at (0,0), i.e. next x=1 (or x=0, y=1 if W==1);
- leave frame_count unchanged.
REQ-016 SHALL, if in_sof=0 is accepted at (0,0), set sof_err and advance the counters normally, storing tuser=1.
REQ-017 SHALL, if in_eol differs from eol_c on an accept, set eol_err; the stored tlast SHALL be eol_c in all cases.
REQ-018 SHALL write {r,g,b,sof_c (or the resynced value),eol_c} into a FIFO_DEPTH-entry FIFO on each accept.
REQ-019 SHALL drive m_axis_tvalid = (fifo_count != 0), with tdata/tuser/tlast taken from the FIFO head; the FIFO pops on tvalid && tready.
REQ-020 SHALL present an accepted pixel on m_axis no earlier than the cycle after its accept (latency 1 when the FIFO is empty); there is no same-cycle bypass.
REQ-021 SHALL hold m_axis_tdata/tuser/tlast stable while tvalid=1 and tready=0.
REQ-022 SHALL, on a simultaneous push and pop, leave fifo_count unchanged and preserve order; when full, no push occurs (in_ready=0) even if a pop happens in that cycle.
REQ-023 SHALL clear sof_err and eol_err when clear_err=1; if an error event occurs in the same cycle, set SHALL win.
REQ-024 SHALL be fully synchronous, with no combinational output-to-input loops.

Reset
REQ-025 SHALL, while aresetn=0 at a clock edge, clear the following state:
- FIFO flushed, fifo_count=0;
- x=y=0, frame_count=0;
- sof_err=eol_err=0;
- m_axis_tvalid=0, tdata=0, tuser=0, tlast=0.
REQ-026 SHALL hold in_ready=0 in any cycle where aresetn=0, and set in_ready=1 in the first cycle after release.
REQ-027 SHALL discard FIFO contents and restart position at (0,0) on a reset asserted mid-frame; the next accepted pixel carries tuser=1.

Verification
REQ-028 W=4,H=2, 8 contiguous pixels, tready=1 -> 8 beats each 1 cycle after accept; tuser on beat 0; tlast on beats 3 and 7; frame_count=1 after the 8th accept.
REQ-029 tready=0, in_valid=1 for 6 cycles -> exactly 4 accepts, then in_ready=0 with fifo_count=4; tready=1 -> 4 beats in input order, in_ready returns to 1 the cycle after the first pop.
REQ-030 W=4,H=2, 3 pixels then a pixel with in_sof=1 -> sof_err=1; that beat has tuser=1; the next tlast comes 3 beats later; frame_count=0.
REQ-031 W=4, in_eol=1 on x=2 and 0 on x=3 -> eol_err=1; tlast=0 on x=2 and tlast=1 on x=3.
REQ-032 clear_err=1 in the same cycle as a new EOL mismatch -> eol_err stays 1; clear_err=1 alone next cycle -> eol_err=0.
REQ-033 FIFO holding 3 pixels mid-frame, aresetn=0 for 1 cycle -> tvalid=0 and in_ready=0 that cycle; the next accepted pixel emerges with tuser=1 and counters at (0,0).

Source files
------------

// File: rtl/pixel_stream_packer.sv
// -----------------------------------------------------------------------------
// pixel_stream_packer
//
// Packs the ray-tracing unit's pixel stream into AXI4-Stream video. The block
// tracks the write-side raster position, generates SOF (tuser) and EOL (tlast)
// from frame geometry, and records framing disagreements with the upstream
// in_sof / in_eol markers in sticky error flags. Accepted pixels pass through
// a FIFO_DEPTH-entry buffer. That buffer decouples in_ready from m_axis_tready.
//
// Parameters
//   FIFO_DEPTH    output buffer entries (power of two, >= 2)
//
// Ports
//   aclk          clock, all logic on the rising edge
//   aresetn       synchronous active-low reset
//   image_width   frame width in pixels (0 behaves as 1)
//   image_height  frame height in pixels (0 behaves as 1)
//   in_valid      upstream pixel valid
//   in_ready      pixel accepted when in_valid && in_ready
//   in_r/g/b      pixel colour components
//   in_sof        upstream start-of-frame marker
//   in_eol        upstream end-of-line marker
//   m_axis_*      AXI4-Stream video output; tdata = {r,g,b}, tuser = SOF,
//                 tlast = EOL
//   clear_err     clears sof_err / eol_err (a same-cycle error event wins)
//   sof_err       sticky: in_sof disagreed with the tracked position
//   eol_err       sticky: in_eol disagreed with the tracked position
//   frame_count   number of completed frames, wraps modulo 2^16
// -----------------------------------------------------------------------------
module pixel_stream_packer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [12:0] image_width,
  input  logic [12:0] image_height,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic        in_sof,
  input  logic        in_eol,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic        clear_err,
  output logic        sof_err,
  output logic        eol_err,
  output logic [15:0] frame_count
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 26;  // {r,g,b,sof,eol}
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Raster position and latched frame geometry
  logic [12:0] x_q, x_d;
  logic [12:0] y_q, y_d;
  logic [12:0] w_q, w_d;
  logic [12:0] h_q, h_d;
  logic [15:0] fc_q, fc_d;

  // Sticky error flags
  logic sof_err_q, sof_err_d;
  logic eol_err_q, eol_err_d;

  // Per-accept decode
  logic               push_s;
  logic               pop_s;
  logic               at_origin_s;
  logic               resync_s;
  logic               eol_c_s;
  logic               tuser_s;
  logic               sof_set_s;
  logic               eol_set_s;
  logic [12:0]        live_w_s;
  logic [12:0]        live_h_s;
  logic [12:0]        cur_w_s;
  logic [12:0]        cur_h_s;
  logic [ENTRY_W-1:0] wr_entry_s;
  logic [ENTRY_W-1:0] head_s;

  // Handshakes: both depend only on registered state and the reset pin.
  assign in_ready      = aresetn & (count_q < DEPTH_C);
  assign m_axis_tvalid = aresetn & (count_q != {CNT_W{1'b0}});
  assign push_s        = in_valid & in_ready;
  assign pop_s         = m_axis_tvalid & m_axis_tready;

  // Geometry of value 0 behaves as 1.
  assign live_w_s = (image_width  == 13'd0) ? 13'd1 : image_width;
  assign live_h_s = (image_height == 13'd0) ? 13'd1 : image_height;

  // The first pixel of a frame sees the live geometry. The latched copy is
  // used for the rest of the frame, so changes to image_width/height
  // mid-frame have no effect until the next frame.
  assign at_origin_s = (x_q == 13'd0) && (y_q == 13'd0);
  assign cur_w_s     = at_origin_s ? live_w_s : w_q;
  assign cur_h_s     = at_origin_s ? live_h_s : h_q;
  assign eol_c_s     = (x_q == (cur_w_s - 13'd1));

  // An unexpected in_sof restarts the frame on this pixel, so it is marked SOF.
  assign resync_s   = in_sof & ~at_origin_s;
  assign tuser_s    = at_origin_s | in_sof;
  assign wr_entry_s = {in_r, in_g, in_b, tuser_s, eol_c_s};

  assign head_s       = fifo_q[rd_ptr_q];
  assign m_axis_tdata = head_s[25:2];
  assign m_axis_tuser = head_s[1];
  assign m_axis_tlast = head_s[0];

  assign sof_err     = sof_err_q;
  assign eol_err     = eol_err_q;
  assign frame_count = fc_q;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Raster position, geometry latch, frame counter and framing-error detection
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    fc_d      = fc_q;
    sof_set_s = 1'b0;
    eol_set_s = 1'b0;
    if (push_s) begin
      sof_set_s = in_sof ^ at_origin_s;
      eol_set_s = in_eol ^ eol_c_s;
      if (resync_s) begin
        // Treat this pixel as (0,0) of a new frame. This is not counted as a
        // completed frame.
        w_d = live_w_s;
        h_d = live_h_s;
        if (live_w_s == 13'd1) begin
          x_d = 13'd0;
          if (live_h_s == 13'd1) begin
            y_d = 13'd0;
          end else begin
            y_d = 13'd1;
          end
        end else begin
          x_d = 13'd1;
          y_d = 13'd0;
        end
      end else begin
        if (at_origin_s) begin
          w_d = live_w_s;
          h_d = live_h_s;
        end else begin
          w_d = w_q;
          h_d = h_q;
        end
        if (eol_c_s) begin
          x_d = 13'd0;
          if (y_q == (cur_h_s - 13'd1)) begin
            y_d  = 13'd0;
            fc_d = fc_q + 16'd1;
          end else begin
            y_d  = y_q + 13'd1;
            fc_d = fc_q;
          end
        end else begin
          x_d = x_q + 13'd1;
          y_d = y_q;
        end
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
      w_d = w_q;
      h_d = h_q;
    end
  end

  // Sticky flags: a new error event takes priority over clear_err
  always_comb begin
    sof_err_d = sof_err_q;
    eol_err_d = eol_err_q;
    if (sof_set_s) begin
      sof_err_d = 1'b1;
    end else if (clear_err) begin
      sof_err_d = 1'b0;
    end else begin
      sof_err_d = sof_err_q;
    end
    if (eol_set_s) begin
      eol_err_d = 1'b1;
    end else if (clear_err) begin
      eol_err_d = 1'b0;
    end else begin
      eol_err_d = eol_err_q;
    end
  end

  // Control state registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      x_q       <= 13'd0;
      y_q       <= 13'd0;
      w_q       <= 13'd1;
      h_q       <= 13'd1;
      fc_q      <= 16'd0;
      sof_err_q <= 1'b0;
      eol_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      h_q       <= h_d;
      fc_q      <= fc_d;
      sof_err_q <= sof_err_d;
      eol_err_q <= eol_err_d;
    end
  end

  // FIFO storage. It is cleared on reset so the output beat reads as zero.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= {ENTRY_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= wr_entry_s;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_packer.sv
module tb_pixel_stream_packer;

  localparam int DEPTH = 4;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [12:0] image_width, image_height;
  logic        in_valid, in_ready;
  logic [7:0]  in_r, in_g, in_b;
  logic        in_sof, in_eol;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
  logic        clear_err, sof_err, eol_err;
  logic [15:0] frame_count;

  pixel_stream_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .image_width(image_width), .image_height(image_height),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_sof(in_sof), .in_eol(in_eol),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast),
    .clear_err(clear_err), .sof_err(sof_err), .eol_err(eol_err),
    .frame_count(frame_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [23:0] d;
    logic        u;
    logic        l;
    int          c;
  } beat_t;

  beat_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit strict_lat = 1'b0;
  bit popped_now = 1'b0;

  // Reference model state: the pixel index within the frame, plus the latched
  // geometry.
  int m_n = 0, m_wl = 1, m_hl = 1, m_frames = 0, acc_total = 0;
  bit m_sof_err = 1'b0, m_eol_err = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  function automatic int eff(logic [12:0] v);
    return (v == 13'd0) ? 1 : int'(v);
  endfunction

  function automatic bit auto_sof();
    return m_n == 0;
  endfunction

  function automatic bit auto_eol();
    int w;
    w = (m_n == 0) ? eff(image_width) : m_wl;
    return (m_n % w) == (w - 1);
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  // Monitor: compares every output beat against the scoreboard
  always @(negedge aclk) begin
    beat_t e;
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      popped_now = 1'b1;
      if (sb_q.size() == 0) begin
        check("spurious_beat", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check("tdata", m_axis_tdata, e.d);
        check("tuser", m_axis_tuser, e.u);
        check("tlast", m_axis_tlast, e.l);
        if (strict_lat) check("latency", cyc - e.c, 1);
      end
    end
  end

  // Reference model: checks flags and handshakes, and predicts each accept
  always @(negedge aclk) begin
    int  occ, w, h, x;
    bit  orig, eolc, acc, exp_rdy, sof_set, eol_set;
    beat_t e;
    #1;
    occ = sb_q.size() + (popped_now ? 1 : 0);
    popped_now = 1'b0;
    exp_rdy = (aresetn === 1'b1) && (occ < DEPTH);
    check("in_ready", in_ready, exp_rdy);
    check("tvalid", m_axis_tvalid, (aresetn === 1'b1) && (occ != 0));
    check("sof_err", sof_err, m_sof_err);
    check("eol_err", eol_err, m_eol_err);
    check("frame_count", frame_count, m_frames[15:0]);
    if (aresetn !== 1'b1) begin
      sb_q.delete();
      m_n = 0; m_frames = 0; m_sof_err = 1'b0; m_eol_err = 1'b0;
    end else begin
      acc     = (in_valid === 1'b1) && exp_rdy;
      sof_set = 1'b0;
      eol_set = 1'b0;
      if (acc) begin
        orig = (m_n == 0);
        w    = orig ? eff(image_width)  : m_wl;
        h    = orig ? eff(image_height) : m_hl;
        x    = m_n % w;
        eolc = (x == w - 1);
        e.d = {in_r, in_g, in_b};
        e.u = orig | in_sof;
        e.l = eolc;
        e.c = cyc;
        sb_q.push_back(e);
        acc_total++;
        sof_set = (in_sof != orig);
        eol_set = (in_eol != eolc);
        if (in_sof && !orig) begin
          m_wl = eff(image_width);
          m_hl = eff(image_height);
          m_n  = (m_wl * m_hl == 1) ? 0 : 1;
        end else begin
          if (orig) begin m_wl = w; m_hl = h; end
          m_n++;
          if (m_n == m_wl * m_hl) begin
            m_n = 0;
            m_frames = (m_frames + 1) % 65536;
          end
        end
      end
      m_sof_err = sof_set || (m_sof_err && !clear_err);
      m_eol_err = eol_set || (m_eol_err && !clear_err);
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Present one pixel and hold it until it is accepted. A mode of -1 means
  // the marker follows the model position; 0 or 1 forces the marker.
  task automatic send(input int sof_mode, input int eol_mode, input bit clr);
    bit acc;
    int guard;
    in_valid  = 1'b1;
    in_r      = 8'($urandom);
    in_g      = 8'($urandom);
    in_b      = 8'($urandom);
    in_sof    = (sof_mode < 0) ? auto_sof() : (sof_mode != 0);
    in_eol    = (eol_mode < 0) ? auto_eol() : (eol_mode != 0);
    clear_err = clr;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 100) begin
      @(negedge aclk);
      acc = in_ready;
      @(posedge aclk);
      #1;
      guard++;
    end
    check("send_accept", acc, 1);
    clear_err = 1'b0;
  endtask

  task automatic idle(input int n, input bit clr);
    in_valid  = 1'b0;
    clear_err = clr;
    repeat (n) step();
    clear_err = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a0, fc0, guard;
    aresetn = 1'b0; in_valid = 1'b0; m_axis_tready = 1'b0; clear_err = 1'b0;
    image_width = 13'd4; image_height = 13'd2;
    in_r = 8'd0; in_g = 8'd0; in_b = 8'd0; in_sof = 1'b0; in_eol = 1'b0;
    repeat (3) step();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_fc", frame_count, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("ready_after_release", in_ready, 1);
    @(posedge aclk); #1;

    // Full 4x2 frame with a contiguous stream and no backpressure
    m_axis_tready = 1'b1;
    strict_lat = 1'b1;
    repeat (8) send(-1, -1, 1'b0);
    check("fc_after_frame", frame_count, 1);
    idle(3, 1'b0);
    strict_lat = 1'b0;

    // Backpressure: six cycles of valid with tready low
    m_axis_tready = 1'b0;
    a0 = acc_total;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
      in_sof = auto_sof(); in_eol = auto_eol();
      step();
    end
    in_valid = 1'b0;
    check("bp_accepts", acc_total - a0, 4);
    check("bp_full_ready", in_ready, 0);
    m_axis_tready = 1'b1;
    idle(6, 1'b0);

    // Mid-frame reset with three pixels buffered
    m_axis_tready = 1'b0;
    repeat (3) send(-1, -1, 1'b0);
    aresetn = 1'b0;
    @(negedge aclk);
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    check("midrst_tdata", m_axis_tdata, 0);
    m_axis_tready = 1'b1;
    send(-1, -1, 1'b0);
    check("postrst_tvalid", m_axis_tvalid, 1);
    check("postrst_tuser", m_axis_tuser, 1);
    repeat (7) send(-1, -1, 1'b0);

    // Unexpected SOF at x=3 of the first line
    fc0 = m_frames;
    repeat (3) send(-1, -1, 1'b0);
    send(1, -1, 1'b0);
    check("resync_sof_err", sof_err, 1);
    check("resync_fc", frame_count, fc0[15:0]);
    repeat (3) send(-1, -1, 1'b0);

    // EOL mismatches on the second line
    send(-1, -1, 1'b0);
    send(-1, -1, 1'b0);
    send(-1, 1, 1'b0);
    send(-1, 0, 1'b0);
    check("eol_err_set", eol_err, 1);
    idle(1, 1'b1);
    check("eol_err_cleared", eol_err, 0);
    check("sof_err_cleared", sof_err, 0);

    // A clear in the same cycle as a new error: the set wins
    send(-1, -1, 1'b0);
    send(-1, -1, 1'b0);
    send(-1, 1, 1'b1);
    check("set_beats_clear", eol_err, 1);
    idle(1, 1'b1);
    check("clear_alone", eol_err, 0);

    // Randomised traffic with geometry changes, marker faults, clears and resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        image_width  = 13'($urandom_range(0, 5));
        image_height = 13'($urandom_range(0, 3));
      end
      aresetn       = ($urandom_range(0, 299) != 0);
      in_valid      = ($urandom_range(0, 3) != 0);
      in_r          = 8'($urandom);
      in_g          = 8'($urandom);
      in_b          = 8'($urandom);
      in_sof        = auto_sof() ^ ($urandom_range(0, 15) == 0);
      in_eol        = auto_eol() ^ ($urandom_range(0, 15) == 0);
      clear_err     = ($urandom_range(0, 19) == 0);
      m_axis_tready = ($urandom_range(0, 9) < 7);
      step();
    end

    // Drain the remaining beats
    aresetn = 1'b1; in_valid = 1'b0; clear_err = 1'b0; m_axis_tready = 1'b1;
    guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      step();
      guard++;
    end
    step();
    check("drain_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
